// File: rtl/dual_port_ram_responder.sv
// dual_port_ram_responder: true dual-port RAM with fixed read/write latency pipelines per port.
// Reads sample the array at acceptance; writes commit WRITE_LATENCY-1 edges later, port A winning same-edge collisions.
module dual_port_ram_responder #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 3,
   parameter int READ_LATENCY  = 3,
   parameter int WRITE_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_wr,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  a_rd_valid,
   output logic                  a_wr_done,
   input  logic                  b_req,
   input  logic                  b_wr,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  b_rd_valid,
   output logic                  b_wr_done
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int WS    = (WRITE_LATENCY > 1) ? WRITE_LATENCY - 1 : 1;
   logic [1:0]            req, wr;
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [DATA_WIDTH-1:0] wdata [2];
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  rv_q [2][READ_LATENCY];
   logic [DATA_WIDTH-1:0] rd_q [2][READ_LATENCY];
   logic                  wv_q [2][WS];
   logic [ADDR_WIDTH-1:0] wa_q [2][WS];
   logic [DATA_WIDTH-1:0] wd_q [2][WS];
   logic [1:0]            wr_done_q;
   logic [1:0]            commit_v;
   logic [ADDR_WIDTH-1:0] commit_a [2];
   logic [DATA_WIDTH-1:0] commit_d [2];
   assign req   = {b_req, a_req};
   assign wr    = {b_wr, a_wr};
   assign addr  = '{a_addr, b_addr};
   assign wdata = '{a_wdata, b_wdata};
   // With a single-cycle write latency the commit happens at the acceptance edge itself.
   for (genvar p = 0; p < 2; p++) begin : g_commit
      assign commit_v[p] = (WRITE_LATENCY == 1) ? req[p] & wr[p] : wv_q[p][WS-1];
      assign commit_a[p] = (WRITE_LATENCY == 1) ? addr[p] : wa_q[p][WS-1];
      assign commit_d[p] = (WRITE_LATENCY == 1) ? wdata[p] : wd_q[p][WS-1];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
               rv_q[p][k] <= 1'b0;
               rd_q[p][k] <= '0;
            end
            for (int k = 0; k < WS; k++) begin
               wv_q[p][k] <= 1'b0;
               wa_q[p][k] <= '0;
               wd_q[p][k] <= '0;
            end
         end
         wr_done_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            rv_q[p][0] <= req[p] & ~wr[p];
            if (req[p] & ~wr[p]) rd_q[p][0] <= mem_q[addr[p]];
            for (int k = 1; k < READ_LATENCY; k++) begin
               rv_q[p][k] <= rv_q[p][k-1];
               if (rv_q[p][k-1]) rd_q[p][k] <= rd_q[p][k-1];
            end
            wv_q[p][0] <= req[p] & wr[p];
            if (req[p] & wr[p]) begin
               wa_q[p][0] <= addr[p];
               wd_q[p][0] <= wdata[p];
            end
            for (int k = 1; k < WS; k++) begin
               wv_q[p][k] <= wv_q[p][k-1];
               wa_q[p][k] <= wa_q[p][k-1];
               wd_q[p][k] <= wd_q[p][k-1];
            end
         end
         // Port A is written last so it wins a same-address collision.
         if (commit_v[1]) mem_q[commit_a[1]] <= commit_d[1];
         if (commit_v[0]) mem_q[commit_a[0]] <= commit_d[0];
         wr_done_q <= commit_v;
      end
   end
   assign a_rdata    = rd_q[0][READ_LATENCY-1];
   assign a_rd_valid = rv_q[0][READ_LATENCY-1];
   assign b_rdata    = rd_q[1][READ_LATENCY-1];
   assign b_rd_valid = rv_q[1][READ_LATENCY-1];
   assign a_wr_done  = wr_done_q[0];
   assign b_wr_done  = wr_done_q[1];
endmodule

// File: tb/tb_dual_port_ram_responder.sv
// tb_dual_port_ram_responder: directed and random checks against a transaction-level memory model.
module tb_dual_port_ram_responder;
   localparam int RL   = 3;
   localparam int WL   = 3;
   localparam int MAXC = 4096;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
   logic [2:0] a_addr = 0, b_addr = 0;
   logic [7:0] a_wdata = 0, b_wdata = 0;
   logic [7:0] a_rdata, b_rdata;
   logic       a_rd_valid, a_wr_done, b_rd_valid, b_wr_done;
   int         n_assert = 0, n_fail = 0;
   int         n = 0, base = 0;
   logic [7:0] mem_m [8];
   logic [7:0] last_m [2];
   logic       rq_v [2][MAXC];
   logic [7:0] rq_d [2][MAXC];
   logic       wq_v [2][MAXC];
   logic [2:0] wq_a [2][MAXC];
   logic [7:0] wq_d [2][MAXC];

   dual_port_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_rd_valid(a_rd_valid), .a_wr_done(a_wr_done),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_rd_valid(b_rd_valid), .b_wr_done(b_wr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   // One clock cycle: drive a request pair, advance the model at the edge, then compare every output.
   task automatic step(input logic ar, input logic aw, input logic [2:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [7:0] bd);
      int r, c;
      logic ev, wd;
      a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
      @(posedge clk);
      rq_v[0][n] = ar & ~aw; rq_d[0][n] = mem_m[aa];
      rq_v[1][n] = br & ~bw; rq_d[1][n] = mem_m[ba];
      wq_v[0][n] = ar & aw;  wq_a[0][n] = aa; wq_d[0][n] = ad;
      wq_v[1][n] = br & bw;  wq_a[1][n] = ba; wq_d[1][n] = bd;
      c = n - WL + 1;
      if (c >= base) begin
         if (wq_v[1][c]) mem_m[wq_a[1][c]] = wq_d[1][c];
         if (wq_v[0][c]) mem_m[wq_a[0][c]] = wq_d[0][c];
      end
      #1;
      r = n - RL + 1;
      for (int p = 0; p < 2; p++) begin
         ev = 1'b0;
         wd = 1'b0;
         if (r >= base) ev = rq_v[p][r];
         if (c >= base) wd = wq_v[p][c];
         if (ev) last_m[p] = rq_d[p][r];
         chk(p == 0 ? "a_rd_valid" : "b_rd_valid", {7'b0, p == 0 ? a_rd_valid : b_rd_valid}, {7'b0, ev});
         chk(p == 0 ? "a_rdata" : "b_rdata", p == 0 ? a_rdata : b_rdata, last_m[p]);
         chk(p == 0 ? "a_wr_done" : "b_wr_done", {7'b0, p == 0 ? a_wr_done : b_wr_done}, {7'b0, wd});
      end
      n++;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      a_req = 0; b_req = 0;
      #1;
      chk("rst_a_rd_valid", {7'b0, a_rd_valid}, 8'h00);
      chk("rst_b_rd_valid", {7'b0, b_rd_valid}, 8'h00);
      chk("rst_a_wr_done", {7'b0, a_wr_done}, 8'h00);
      chk("rst_b_wr_done", {7'b0, b_wr_done}, 8'h00);
      chk("rst_a_rdata", a_rdata, 8'h00);
      chk("rst_b_rdata", b_rdata, 8'h00);
      for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
      last_m[0] = 8'h00;
      last_m[1] = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      base = n;
   endtask

   initial begin
      do_reset();
      // Write then read back on port A.
      step(1, 1, 3, 8'hA5, 0, 0, 0, 0);
      idle();
      idle();
      chk("t1_wr_done", {7'b0, a_wr_done}, 8'h01);
      step(1, 0, 3, 0, 0, 0, 0, 0);
      idle();
      idle();
      chk("t1_rd_valid", {7'b0, a_rd_valid}, 8'h01);
      chk("t1_rdata", a_rdata, 8'hA5);
      // Read-after-write: reads at or before the commit edge see old data.
      step(1, 1, 1, 8'h5C, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      chk("raw_e1", a_rdata, 8'h00);
      idle();
      chk("raw_e2", a_rdata, 8'h00);
      idle();
      chk("raw_e3", a_rdata, 8'h5C);
      chk("raw_e3_valid", {7'b0, a_rd_valid}, 8'h01);
      // Same-edge write collision: A wins.
      step(1, 1, 6, 8'h11, 1, 1, 6, 8'h22);
      idle();
      idle();
      chk("col_a_done", {7'b0, a_wr_done}, 8'h01);
      chk("col_b_done", {7'b0, b_wr_done}, 8'h01);
      step(0, 0, 0, 0, 1, 0, 6, 0);
      idle();
      idle();
      chk("col_data", b_rdata, 8'h11);
      // Prefill addr*3, then stream reads on port B.
      for (int i = 0; i < 8; i++) step(1, 1, 3'(i), 8'(i * 3), 0, 0, 0, 0);
      idle();
      idle();
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, i < 8, 0, 3'(i), 0);
         if (i >= 2) begin
            chk("stream_valid", {7'b0, b_rd_valid}, 8'h01);
            chk("stream_data", b_rdata, 8'((i - 2) * 3));
         end
      end
      idle();
      chk("stream_end", {7'b0, b_rd_valid}, 8'h00);
      // Concurrent: A writes addr 2 while B reads addr 5.
      for (int i = 0; i < 5; i++) begin
         step(i < 3, 1, 2, 8'h77, i < 3, 0, 5, 0);
         if (i >= 2) chk("conc_b_data", b_rdata, 8'h0F);
      end
      // Randomised traffic against the model.
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom), 8'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom), 8'($urandom));
      // Mid-flight reset discards in-flight work and clears the array.
      step(1, 0, 4, 0, 1, 1, 7, 8'hEE);
      idle();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("mid_no_pulse", {7'b0, a_rd_valid | b_wr_done}, 8'h00);
      end
      for (int i = 0; i < 10; i++) begin
         step(i < 8, 0, 3'(i), 0, i < 8, 0, 3'(7 - i), 0);
         if (i >= 2) begin
            chk("mid_a_zero", a_rdata, 8'h00);
            chk("mid_b_zero", b_rdata, 8'h00);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
